// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard control for a five-stage pipeline.
// Keeps shadow copies of the destination info for the EX, MEM and WB
// instructions, so only ID-stage decode fields are needed. It produces
// the registered EX operand-mux selects, the combinational ID
// branch-compare selects, the load-use/branch stall, and a saturating
// count of stall cycles.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_is_branch,
  input  logic              id_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              cmp_fwd_a,
  output logic              cmp_fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10
  } fwd_sel_e;

  slot_t ex_slot, mem_slot, wb_slot;
  slot_t id_slot;

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic load_use, br_haz, load_ex;

  // A slot produces register r only if it is a live writer of a nonzero register
  function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.regwrite & (s.rd == r) & (r != '0);
  endfunction

  // Operand select for the instruction entering EX: the old EX becomes MEM
  // and the old MEM becomes WB, so the nearer producer takes priority
  function automatic fwd_sel_e pick(input logic use_x, input logic [REG_AW-1:0] r,
                                    input slot_t near, input slot_t far);
    if (!use_x)             return SEL_RF;
    else if (writes(near, r)) return SEL_MEM;
    else if (writes(far, r))  return SEL_WB;
    else                      return SEL_RF;
  endfunction

  // Match the ID sources against in-flight producers and derive stall/compare selects
  always_comb begin
    id_slot  = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
    ex_rs    = id_use_rs & writes(ex_slot, id_rs);
    ex_rt    = id_use_rt & writes(ex_slot, id_rt);
    mem_rs   = id_use_rs & writes(mem_slot, id_rs);
    mem_rt   = id_use_rt & writes(mem_slot, id_rt);
    load_use = ex_slot.memread & (ex_rs | ex_rt);
    br_haz   = id_is_branch & ((ex_rs | ex_rt) | (mem_slot.memread & (mem_rs | mem_rt)));
    stall    = rst_n & id_valid & ~id_flush & (load_use | br_haz);
    cmp_fwd_a = rst_n & id_is_branch & mem_rs & ~mem_slot.memread;
    cmp_fwd_b = rst_n & id_is_branch & mem_rt & ~mem_slot.memread;
    load_ex  = id_valid & ~stall & ~id_flush;
  end

  // Advance the shadow slots, register the EX selects and count stall cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_slot     <= '0;
      mem_slot    <= '0;
      wb_slot     <= '0;
      fwd_a       <= SEL_RF;
      fwd_b       <= SEL_RF;
      stall_count <= '0;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= load_ex ? id_slot : '0;
      fwd_a    <= load_ex ? pick(id_use_rs, id_rs, ex_slot, mem_slot) : SEL_RF;
      fwd_b    <= load_ex ? pick(id_use_rt, id_rt, ex_slot, mem_slot) : SEL_RF;
      if (stall && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt;
  logic        id_regwrite, id_memread, id_is_branch, id_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        cmp_fwd_a, cmp_fwd_b, stall;
  logic [15:0] stall_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_is_branch(id_is_branch),
    .id_flush(id_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .cmp_fwd_a(cmp_fwd_a),
    .cmp_fwd_b(cmp_fwd_b), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic br, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_is_branch = br; id_flush = fl;
    #1;
  endtask

  task automatic nop();                      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_id(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic ld(input logic [4:0] rd, input logic [4:0] rs);
    set_id(1'b1, rs, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
    set_id(1'b1, rs, rt, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop(); step(); step(); step();
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    step(); step();
    check("reset fwd_a", 16'(fwd_a), 16'd0);
    check("reset fwd_b", 16'(fwd_b), 16'd0);
    check("reset stall", 16'(stall), 16'd0);
    check("reset count", stall_count, 16'd0);
    rst_n = 1'b1;
    step();

    // distance-1: add r3,r1,r2 ; sub r4,r3,r5
    alu(5'd3, 5'd1, 5'd2);
    check("d1 add stall", 16'(stall), 16'd0);
    step();
    alu(5'd4, 5'd3, 5'd5);
    check("d1 sub stall", 16'(stall), 16'd0);
    step();
    nop();
    check("d1 fwd_a", 16'(fwd_a), 16'd1);
    check("d1 fwd_b", 16'(fwd_b), 16'd0);
    drain();

    // distance-2: add r3 ; nop ; or r6,r7,r3
    alu(5'd3, 5'd1, 5'd2); step();
    nop(); step();
    alu(5'd6, 5'd7, 5'd3); step();
    nop();
    check("d2 fwd_a", 16'(fwd_a), 16'd0);
    check("d2 fwd_b", 16'(fwd_b), 16'd2);
    drain();

    // priority: add r3 ; add r3 ; or r6,r3,r3
    alu(5'd3, 5'd1, 5'd2); step();
    alu(5'd3, 5'd1, 5'd2); step();
    alu(5'd6, 5'd3, 5'd3); step();
    nop();
    check("prio fwd_a", 16'(fwd_a), 16'd1);
    check("prio fwd_b", 16'(fwd_b), 16'd1);
    drain();

    // load-use: lw r8 ; add r9,r8,r8
    ld(5'd8, 5'd1); step();
    alu(5'd9, 5'd8, 5'd8);
    check("lu stall", 16'(stall), 16'd1);
    step();
    check("lu bubble fwd_a", 16'(fwd_a), 16'd0);
    check("lu bubble fwd_b", 16'(fwd_b), 16'd0);
    check("lu stall gone", 16'(stall), 16'd0);
    step();
    nop();
    check("lu fwd_a", 16'(fwd_a), 16'd2);
    check("lu fwd_b", 16'(fwd_b), 16'd2);
    check("lu count", stall_count, 16'd1);
    drain();

    // add r1 ; beq r1,r2
    alu(5'd1, 5'd2, 5'd3); step();
    beq(5'd1, 5'd2);
    check("ba stall", 16'(stall), 16'd1);
    check("ba cmp_a early", 16'(cmp_fwd_a), 16'd0);
    step();
    check("ba stall gone", 16'(stall), 16'd0);
    check("ba cmp_a", 16'(cmp_fwd_a), 16'd1);
    check("ba cmp_b", 16'(cmp_fwd_b), 16'd0);
    step();
    drain();

    // lw r1 ; beq r1,r2
    ld(5'd1, 5'd2); step();
    beq(5'd1, 5'd2);
    check("bl stall1", 16'(stall), 16'd1);
    step();
    check("bl stall2", 16'(stall), 16'd1);
    check("bl cmp_a mid", 16'(cmp_fwd_a), 16'd0);
    step();
    check("bl stall end", 16'(stall), 16'd0);
    check("bl cmp_a", 16'(cmp_fwd_a), 16'd0);
    step();
    check("bl count", stall_count, 16'd4);
    drain();

    // r0 never forwards: add r0 ; sub r4,r0,r0
    alu(5'd0, 5'd1, 5'd2); step();
    alu(5'd4, 5'd0, 5'd0); step();
    nop();
    check("r0 fwd_a", 16'(fwd_a), 16'd0);
    check("r0 fwd_b", 16'(fwd_b), 16'd0);
    drain();

    // flush overrides load-use stall
    ld(5'd8, 5'd1); step();
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    check("fl stall", 16'(stall), 16'd0);
    step();
    nop();
    check("fl bubble fwd_a", 16'(fwd_a), 16'd0);
    check("fl count", stall_count, 16'd4);
    drain();

    // reset during a load-use stall
    ld(5'd8, 5'd1); step();
    alu(5'd9, 5'd8, 5'd8);
    check("rs stall", 16'(stall), 16'd1);
    rst_n = 1'b0;
    #1;
    check("rs stall forced", 16'(stall), 16'd0);
    step();
    check("rs fwd_a", 16'(fwd_a), 16'd0);
    check("rs fwd_b", 16'(fwd_b), 16'd0);
    check("rs count", stall_count, 16'd0);
    rst_n = 1'b1;
    #1;
    check("rs no stall after", 16'(stall), 16'd0);
    step();
    drain();
    ld(5'd8, 5'd1); step();
    alu(5'd9, 5'd8, 5'd8);
    check("rs2 stall", 16'(stall), 16'd1);
    step();
    check("rs2 stall gone", 16'(stall), 16'd0);
    step();
    nop();
    check("rs2 fwd_a", 16'(fwd_a), 16'd2);
    check("rs2 count", stall_count, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
